// File: rtl/br_csr_iq_release_ctrl.sv
// Release side of the branch/CSR issue-queue free-ID list: busy map, return FIFO and free-list write port.
// Optional feature macro BR_RELEASE_BYPASS_EN: a lone release into an idle FIFO is written to the free list in the same cycle.
module br_csr_iq_release_ctrl #(
  parameter int IDWIDE   = 4,
  parameter int ENTRYNUM = 16,
  parameter int RELQDEEP = 4
) (
  input  logic                Clk,
  input  logic                Rest,
  input  logic                AllocValid,
  input  logic [IDWIDE-1:0]   AllocId,
  input  logic                RelValid0,
  input  logic [IDWIDE-1:0]   RelId0,
  input  logic                RelValid1,
  input  logic [IDWIDE-1:0]   RelId1,
  output logic                RelReady,
  input  logic                Flush,
  input  logic                FreeFull,
  output logic                FreeWable,
  output logic [IDWIDE-1:0]   FreeDin,
  output logic                FreeClean,
  output logic [ENTRYNUM-1:0] BusyMap,
  output logic                ErrDoubleFree
);

  localparam int PW = $clog2(RELQDEEP);
  localparam int CW = PW + 1;

  logic [IDWIDE-1:0]   fifo_mem_r [RELQDEEP];
  logic [PW-1:0]       rd_ptr_r;
  logic [PW-1:0]       wr_ptr_r;
  logic [CW-1:0]       count_r;
  logic [ENTRYNUM-1:0] busy_r;
  logic                err_r;
  logic                clean_r;
  logic [IDWIDE-1:0]   din_hold_r;

  logic                rel_ready_s;
  logic                out_ok_s;
  logic                v0_s;
  logic                v1_s;
  logic                alloc_s;
  logic                pop_s;
  logic                byp_s;
  logic                wable_s;
  logic [1:0]          npush_s;
  logic [IDWIDE-1:0]   push_a_s;
  logic [IDWIDE-1:0]   head_s;
  logic [IDWIDE-1:0]   din_s;
  logic [ENTRYNUM-1:0] busy_nxt_s;
  logic                err_set_s;

  function automatic logic id_bad(input logic [IDWIDE-1:0] id);
    return (32'(id) >= 32'(ENTRYNUM));
  endfunction

  function automatic logic map_bit(input logic [ENTRYNUM-1:0] map, input logic [IDWIDE-1:0] id);
    logic b;
    b = 1'b0;
    for (int i = 0; i < ENTRYNUM; i++) begin
      b = b | (map[i] & (id == IDWIDE'(i)));
    end
    return b;
  endfunction

  // Release acceptance, pop/bypass selection, busy-map next state and error detection.
  always_comb begin
    rel_ready_s = (count_r <= CW'(RELQDEEP - 2));
    head_s      = fifo_mem_r[rd_ptr_r];
    alloc_s     = AllocValid && !Flush;
    // Releases presented without room are dropped whole; they only raise the error.
    v0_s        = RelValid0 && !Flush && rel_ready_s;
    v1_s        = RelValid1 && !Flush && rel_ready_s;
    out_ok_s    = !Rest && !Flush && !clean_r && !FreeFull;
    pop_s       = out_ok_s && (count_r != CW'(0));
    byp_s       = 1'b0;
`ifdef BR_RELEASE_BYPASS_EN
    byp_s       = out_ok_s && (count_r == CW'(0)) && (v0_s || v1_s);
`endif
    wable_s     = pop_s || byp_s;
    if (byp_s) begin
      npush_s  = {1'b0, v0_s && v1_s};
      push_a_s = RelId1;
      din_s    = v0_s ? RelId0 : RelId1;
    end else begin
      npush_s  = {1'b0, v0_s} + {1'b0, v1_s};
      push_a_s = v0_s ? RelId0 : RelId1;
      din_s    = pop_s ? head_s : din_hold_r;
    end
    busy_nxt_s = busy_r;
    for (int i = 0; i < ENTRYNUM; i++) begin
      busy_nxt_s[i] = (busy_r[i] | (alloc_s && (AllocId == IDWIDE'(i))))
                      & ~(v0_s && (RelId0 == IDWIDE'(i)))
                      & ~(v1_s && (RelId1 == IDWIDE'(i)));
    end
    err_set_s = !Flush && (
                  (AllocValid && (id_bad(AllocId) || map_bit(busy_r, AllocId))) ||
                  (RelValid0 && (!rel_ready_s || id_bad(RelId0) || !map_bit(busy_r, RelId0))) ||
                  (RelValid1 && (!rel_ready_s || id_bad(RelId1) || !map_bit(busy_r, RelId1))) ||
                  (RelValid0 && RelValid1 && (RelId0 == RelId1)));
  end

  // FIFO, busy map, sticky error, clean pulse and held write data.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      for (int i = 0; i < RELQDEEP; i++) begin
        fifo_mem_r[i] <= {IDWIDE{1'b0}};
      end
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      busy_r     <= {ENTRYNUM{1'b0}};
      err_r      <= 1'b0;
      clean_r    <= 1'b0;
      din_hold_r <= {IDWIDE{1'b0}};
    end else if (Flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      busy_r   <= {ENTRYNUM{1'b0}};
      clean_r  <= 1'b1;
    end else begin
      if (npush_s != 2'd0) begin
        fifo_mem_r[wr_ptr_r] <= push_a_s;
      end
      if (npush_s == 2'd2) begin
        fifo_mem_r[wr_ptr_r + PW'(1)] <= RelId1;
      end
      wr_ptr_r <= wr_ptr_r + PW'(npush_s);
      rd_ptr_r <= rd_ptr_r + PW'(pop_s);
      count_r  <= count_r + CW'(npush_s) - CW'(pop_s);
      busy_r   <= busy_nxt_s;
      err_r    <= err_r | err_set_s;
      clean_r  <= 1'b0;
      if (wable_s) begin
        din_hold_r <= din_s;
      end
    end
  end

  assign RelReady      = rel_ready_s;
  assign FreeWable     = wable_s;
  assign FreeDin       = din_s;
  assign FreeClean     = clean_r;
  assign BusyMap       = busy_r;
  assign ErrDoubleFree = err_r;

endmodule

// File: tb/tb_br_csr_iq_release_ctrl.sv
// Self-checking bench for br_csr_iq_release_ctrl: directed plan steps plus random traffic against a queue-based model.
module tb_br_csr_iq_release_ctrl;
  localparam int IDW   = 4;
  localparam int NE    = 16;
  localparam int DEPTH = 4;

  logic           Clk = 1'b0;
  logic           Rest;
  logic           AllocValid;
  logic [IDW-1:0] AllocId;
  logic           RelValid0;
  logic [IDW-1:0] RelId0;
  logic           RelValid1;
  logic [IDW-1:0] RelId1;
  logic           RelReady;
  logic           Flush;
  logic           FreeFull;
  logic           FreeWable;
  logic [IDW-1:0] FreeDin;
  logic           FreeClean;
  logic [NE-1:0]  BusyMap;
  logic           ErrDoubleFree;

  int total = 0;
  int bad   = 0;

  // reference model state
  int q[$];
  bit busy_m[NE];
  bit err_m;
  bit clean_m;
  int last_din_m;
  bit exp_wable;
  int exp_din;
  bit exp_ready;
  bit exp_byp;
  // DUT outputs seen at the last pre-edge sample
  logic           seen_wable;
  logic [IDW-1:0] seen_din;
  logic           seen_clean;

  br_csr_iq_release_ctrl #(.IDWIDE(IDW), .ENTRYNUM(NE), .RELQDEEP(DEPTH)) dut (
    .Clk(Clk), .Rest(Rest), .AllocValid(AllocValid), .AllocId(AllocId),
    .RelValid0(RelValid0), .RelId0(RelId0), .RelValid1(RelValid1), .RelId1(RelId1),
    .RelReady(RelReady), .Flush(Flush), .FreeFull(FreeFull), .FreeWable(FreeWable),
    .FreeDin(FreeDin), .FreeClean(FreeClean), .BusyMap(BusyMap), .ErrDoubleFree(ErrDoubleFree)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NE-1:0] busy_vec();
    logic [NE-1:0] v;
    for (int i = 0; i < NE; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NE; i++) busy_m[i] = 1'b0;
    err_m = 1'b0;
    clean_m = 1'b0;
    last_din_m = 0;
  endtask

  task automatic model_eval();
    bit ok, v0, v1;
    exp_ready = (DEPTH - q.size()) >= 2;
    ok = !Flush && !clean_m && !FreeFull;
    v0 = RelValid0 && !Flush && exp_ready;
    v1 = RelValid1 && !Flush && exp_ready;
    exp_byp = 1'b0;
`ifdef BR_RELEASE_BYPASS_EN
    exp_byp = ok && (q.size() == 0) && (v0 || v1);
`endif
    if (exp_byp) begin
      exp_wable = 1'b1;
      exp_din = v0 ? int'(RelId0) : int'(RelId1);
    end else if (ok && q.size() > 0) begin
      exp_wable = 1'b1;
      exp_din = q[0];
    end else begin
      exp_wable = 1'b0;
      exp_din = last_din_m;
    end
  endtask

  task automatic model_commit();
    int ids[$];
    if (Flush) begin
      q.delete();
      for (int i = 0; i < NE; i++) busy_m[i] = 1'b0;
      clean_m = 1'b1;
    end else begin
      clean_m = 1'b0;
      if (exp_wable && !exp_byp) void'(q.pop_front());
      if (exp_wable) last_din_m = exp_din;
      if (AllocValid && busy_m[AllocId]) err_m = 1'b1;
      if (RelValid0 && (!exp_ready || !busy_m[RelId0])) err_m = 1'b1;
      if (RelValid1 && (!exp_ready || !busy_m[RelId1])) err_m = 1'b1;
      if (RelValid0 && RelValid1 && RelId0 == RelId1) err_m = 1'b1;
      if (AllocValid) busy_m[AllocId] = 1'b1;
      if (exp_ready) begin
        if (RelValid0) begin ids.push_back(int'(RelId0)); busy_m[RelId0] = 1'b0; end
        if (RelValid1) begin ids.push_back(int'(RelId1)); busy_m[RelId1] = 1'b0; end
        if (exp_byp) void'(ids.pop_front());
        foreach (ids[k]) q.push_back(ids[k]);
      end
    end
  endtask

  // One clock cycle: drive, compare every output before the edge, then advance the model.
  task automatic step(input bit av, input int aid, input bit r0, input int id0,
                      input bit r1, input int id1, input bit fl, input bit full);
    AllocValid = av; AllocId = aid[IDW-1:0];
    RelValid0 = r0;  RelId0 = id0[IDW-1:0];
    RelValid1 = r1;  RelId1 = id1[IDW-1:0];
    Flush = fl;      FreeFull = full;
    @(negedge Clk);
    model_eval();
    seen_wable = FreeWable;
    seen_din   = FreeDin;
    seen_clean = FreeClean;
    check("wable", FreeWable, exp_wable);
    check("din", FreeDin, exp_din);
    check("ready", RelReady, exp_ready);
    check("busy", BusyMap, busy_vec());
    check("err", ErrDoubleFree, err_m);
    check("clean", FreeClean, clean_m);
    @(posedge Clk);
    model_commit();
    #1;
  endtask

  task automatic idle(input bit full);
    step(0, 0, 0, 0, 0, 0, 0, full);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, BusyMap, 32'h0);
    check({tag, "_wable"}, FreeWable, 32'h0);
    check({tag, "_din"}, FreeDin, 32'h0);
    check({tag, "_clean"}, FreeClean, 32'h0);
    check({tag, "_err"}, ErrDoubleFree, 32'h0);
  endtask

  task automatic pulse_rest();
    Rest = 1'b1;
    @(posedge Clk);
    #1;
    Rest = 1'b0;
    model_reset();
  endtask

  function automatic int pick(input bit want_busy);
    int c[$];
    for (int i = 0; i < NE; i++) if (busy_m[i] == want_busy) c.push_back(i);
    if (c.size() == 0) return int'($urandom_range(NE - 1));
    return c[$urandom_range(c.size() - 1)];
  endfunction

  initial begin
    Rest = 1'b1; AllocValid = 1'b0; AllocId = '0; RelValid0 = 1'b0; RelId0 = '0;
    RelValid1 = 1'b0; RelId1 = '0; Flush = 1'b0; FreeFull = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    check("reset_ready", RelReady, 32'h1);
    Rest = 1'b0;

    // allocation of 1,5,9,13
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0, 0);
    step(1, 9, 0, 0, 0, 0, 0, 0);
    step(1, 13, 0, 0, 0, 0, 0, 0);
    check("plan_busy_2222", BusyMap, 32'h2222);

    // paired release 5,9 drains in order
    step(0, 0, 1, 5, 1, 9, 0, 0);
`ifndef BR_RELEASE_BYPASS_EN
    check("plan_rel_n_wable", seen_wable, 32'h0);
`endif
    idle(0);
`ifndef BR_RELEASE_BYPASS_EN
    check("plan_pop5", {seen_wable, seen_din}, {1'b1, 4'd5});
`endif
    idle(0);
`ifndef BR_RELEASE_BYPASS_EN
    check("plan_pop9", {seen_wable, seen_din}, {1'b1, 4'd9});
`endif
    check("plan_busy_after_rel", BusyMap, 32'h2002);
    check("plan_no_err", ErrDoubleFree, 32'h0);

    // fill the FIFO while the free list is full
    step(1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 13, 0, 1);
    step(0, 0, 1, 2, 1, 3, 0, 1);
    check("plan_full_ready", RelReady, 32'h0);
    idle(0);
    check("plan_drain1", {seen_wable, seen_din}, {1'b1, 4'd1});
    idle(0);
    check("plan_drain13", {seen_wable, seen_din}, {1'b1, 4'd13});
    check("plan_ready_back", RelReady, 32'h1);
    idle(0);
    check("plan_drain2", {seen_wable, seen_din}, {1'b1, 4'd2});
    idle(0);
    check("plan_drain3", {seen_wable, seen_din}, {1'b1, 4'd3});
    idle(0);
    check("plan_drain_empty", seen_wable, 32'h0);

    // double free of 7 is sticky; duplicate pair after reset also flags
    step(0, 0, 1, 7, 0, 0, 0, 0);
    check("plan_err7", ErrDoubleFree, 32'h1);
    idle(0); idle(0); idle(0);
    check("plan_err_sticky", ErrDoubleFree, 32'h1);
    pulse_rest();
    check("plan_err_cleared", ErrDoubleFree, 32'h0);
    step(1, 4, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4, 1, 4, 0, 0);
    check("plan_err_dup", ErrDoubleFree, 32'h1);
    idle(0); idle(0); idle(0);

    // flush with two IDs queued
    step(1, 6, 0, 0, 0, 0, 0, 0);
    step(1, 8, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 6, 1, 8, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("plan_flush_wable", seen_wable, 32'h0);
    check("plan_flush_busy", BusyMap, 32'h0);
    idle(0);
    check("plan_clean_pulse", {seen_clean, seen_wable}, {1'b1, 1'b0});
    idle(0);
    check("plan_clean_done", {seen_clean, seen_wable}, {1'b0, 1'b0});
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("plan_clean_rearm", FreeClean, 32'h1);
    idle(0); idle(0);

    // asynchronous reset with three IDs queued
    pulse_rest();
    step(1, 10, 0, 0, 0, 0, 0, 1);
    step(1, 11, 0, 0, 0, 0, 0, 1);
    step(1, 12, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 10, 1, 11, 0, 1);
    step(0, 0, 1, 12, 0, 0, 0, 1);
    check("plan_pre_rest_busy", BusyMap, 32'h0);
    step(0, 0, 1, 12, 0, 0, 0, 1);
    #2;
    Rest = 1'b1;
    #1;
    check_reset_outputs("async_rest");
    check("async_rest_ready", RelReady, 32'h1);
    model_reset();
    @(posedge Clk);
    #1;
    Rest = 1'b0;
    idle(0);
    check("post_rest_wable0", seen_wable, 32'h0);
    idle(0);
    check("post_rest_wable1", seen_wable, 32'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit av, r0, r1, fl, full;
      int aid, id0, id1;
      if (n % 200 == 199) pulse_rest();
      av   = ($urandom_range(2) == 0);
      aid  = pick($urandom_range(9) == 0);
      r0   = ($urandom_range(2) == 0);
      r1   = ($urandom_range(3) == 0);
      id0  = pick($urandom_range(9) != 0);
      id1  = pick($urandom_range(9) != 0);
      fl   = ($urandom_range(29) == 0);
      full = ($urandom_range(2) == 0);
      step(av, aid, r0, id0, r1, id1, fl, full);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
